// File: rtl/lsl8_iter.sv
// lsl8_iter: iterative logical shift-left unit, up to STEP bits per clock.
// Reports the result, the last bit shifted out of the MSB, and a done pulse.
`default_nettype none

module lsl8_iter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3,
  parameter int STEP    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   d_out,
  output logic               c_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [SHAMT_W-1:0] C_STEP = SHAMT_W'(STEP);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [SHAMT_W-1:0] rem_q,   rem_d;
  logic               carry_q, carry_d;

  logic [SHAMT_W-1:0] step_w;
  logic [SHAMT_W-1:0] rem_next_w;
  logic [WIDTH:0]     ext_w;

  // One extra MSB on the shifter catches the last bit pushed out of the word.
  always_comb begin
    step_w     = (rem_q > C_STEP) ? C_STEP : rem_q;
    rem_next_w = rem_q - step_w;
    ext_w      = {1'b0, data_q} << step_w;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = d_in;
          rem_d   = shamt;
          carry_d = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = ext_w[WIDTH-1:0];
        rem_d  = rem_next_w;
        if (step_w != '0) begin
          carry_d = ext_w[WIDTH];
        end
        if (rem_next_w == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
    end
  end

  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);
  assign d_out = data_q;
  assign c_out = carry_q;

endmodule

`default_nettype wire
